// File: rtl/gpio_if.sv
// Register-file and pad signal bundle for the GPIO pad stage.
// The slave side is the gpio_port; the master side is the register file and pads.
interface gpio_if;
    logic [15:0] rf_gpio_datareg;
    logic [15:0] rf_gpio_tristate;
    logic [15:0] rf_gpio_interrupt_mask;
    logic [15:0] intr_clear;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe;
    logic [15:0] ro_gpio_pinstate;
    logic [15:0] gpio_intr_pending;
    logic        gpio_irq;

    modport slave (
        input  rf_gpio_datareg,
        input  rf_gpio_tristate,
        input  rf_gpio_interrupt_mask,
        input  intr_clear,
        input  gpio_in,
        output gpio_out,
        output gpio_oe,
        output ro_gpio_pinstate,
        output gpio_intr_pending,
        output gpio_irq
    );

    modport master (
        output rf_gpio_datareg,
        output rf_gpio_tristate,
        output rf_gpio_interrupt_mask,
        output intr_clear,
        output gpio_in,
        input  gpio_out,
        input  gpio_oe,
        input  ro_gpio_pinstate,
        input  gpio_intr_pending,
        input  gpio_irq
    );
endinterface

// File: rtl/gpio_port.sv
// GPIO pad stage: registered pad drive, synchronized inputs, sticky edge pending, irq.
// Define GPIO_DEBOUNCE_EN to add a per-pin debounce filter of DEBOUNCE_CYCLES.
module gpio_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic   clk,
    input logic   reset,
    gpio_if.slave bus
);
    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] f;
    logic [15:0] f_prev;
    logic [15:0] edge_evt;
    logic [15:0] pending;
    logic [15:0] out_q;
    logic [15:0] oe_q;
    logic        irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
            oe_q  <= '0;
        end else begin
            out_q <= bus.rf_gpio_datareg;
            oe_q  <= ~bus.rf_gpio_tristate;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.gpio_in;
            s2 <= s1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] LIMIT = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] cnt [16];

    // The counter counts edges already spent disagreeing; the last one commits.
    always_ff @(posedge clk) begin
        if (reset) begin
            f <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (s2[i] == f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LIMIT) begin
                    f[i]   <= s2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end
`else
    assign f = s2;
`endif

    assign edge_evt = f ^ f_prev;

    // A same-cycle set beats the clear so an edge is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_prev  <= '0;
            pending <= '0;
            irq_q   <= 1'b0;
        end else begin
            f_prev  <= f;
            pending <= (pending & ~bus.intr_clear)
                     | (edge_evt & bus.rf_gpio_interrupt_mask);
            irq_q   <= |(pending & bus.rf_gpio_interrupt_mask);
        end
    end

    assign bus.gpio_out          = out_q;
    assign bus.gpio_oe           = oe_q;
    assign bus.ro_gpio_pinstate  = f;
    assign bus.gpio_intr_pending = pending;
    assign bus.gpio_irq          = irq_q;
endmodule

// File: tb/tb_gpio_port.sv
// Bench for gpio_port: directed test-plan cases plus random traffic
// checked every cycle against a sample-history reference model.
module tb_gpio_port;
    localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = DB;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    gpio_if bus ();

    gpio_port #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] m_s1;
    logic [15:0] m_f;
    logic [15:0] m_fprev;
    logic [15:0] m_pend;
    logic [15:0] m_out;
    logic [15:0] m_oe;
    logic        m_irq;
    logic [15:0] m_hist[$];

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t",
                         tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1    = '0;
        m_f     = '0;
        m_fprev = '0;
        m_pend  = '0;
        m_out   = '0;
        m_oe    = '0;
        m_irq   = 1'b0;
        m_hist.delete();
        for (int j = 0; j < DB; j++) m_hist.push_back(16'h0000);
    endtask

    // Pinstate is the input two samples back (or, with debounce, the last
    // value that held for DB consecutive synchronized samples).
    task automatic model_edge();
        logic [15:0] s2_new;
        logic [15:0] f_new;
        if (reset) begin
            model_reset();
            return;
        end
        s2_new = m_s1;
        m_s1   = bus.gpio_in;
`ifdef GPIO_DEBOUNCE_EN
        f_new = m_f;
        for (int p = 0; p < 16; p++) begin
            bit flip;
            flip = 1'b1;
            for (int j = 0; j < DB; j++)
                if (m_hist[j][p] == m_f[p]) flip = 1'b0;
            if (flip) f_new[p] = ~m_f[p];
        end
        m_hist.push_front(s2_new);
        void'(m_hist.pop_back());
`else
        f_new = s2_new;
`endif
        m_irq   = |(m_pend & bus.rf_gpio_interrupt_mask);
        m_pend  = (m_pend & ~bus.intr_clear)
                | ((m_f ^ m_fprev) & bus.rf_gpio_interrupt_mask);
        m_fprev = m_f;
        m_f     = f_new;
        m_out   = bus.rf_gpio_datareg;
        m_oe    = ~bus.rf_gpio_tristate;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("gpio_out", bus.gpio_out, m_out);
        check("gpio_oe", bus.gpio_oe, m_oe);
        check("pinstate", bus.ro_gpio_pinstate, m_f);
        check("pending", bus.gpio_intr_pending, m_pend);
        check("irq", {15'd0, bus.gpio_irq}, {15'd0, m_irq});
    endtask

    logic v5;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        reset   = 1'b1;
        model_reset();
        bus.rf_gpio_datareg        = 16'hFFFF;
        bus.rf_gpio_tristate       = 16'h0000;
        bus.rf_gpio_interrupt_mask = 16'hFFFF;
        bus.intr_clear             = 16'h0000;
        bus.gpio_in                = 16'h0002;

        repeat (3) step();
        check("rst_out", bus.gpio_out, 16'h0000);
        check("rst_oe", bus.gpio_oe, 16'h0000);
        check("rst_pend", bus.gpio_intr_pending, 16'h0000);
        check("rst_irq", {15'd0, bus.gpio_irq}, 16'h0000);

        reset = 1'b0;
        bus.rf_gpio_interrupt_mask = 16'h0000;
        bus.rf_gpio_tristate       = 16'h00FF;
        bus.rf_gpio_datareg        = 16'hA5A5;
        step();
        check("out_a5a5", bus.gpio_out, 16'hA5A5);
        check("oe_ff00", bus.gpio_oe, 16'hFF00);
        repeat (8 + LAT) step();
        check("pin1_nopend", bus.gpio_intr_pending, 16'h0000);

        bus.rf_gpio_interrupt_mask = 16'h0001;
        step();
        bus.gpio_in[0] = 1'b1;
        step();
        repeat (LAT + 1) step();
        check("pin0_state", {15'd0, bus.ro_gpio_pinstate[0]}, 16'h0001);
        step();
        check("pin0_pend", bus.gpio_intr_pending, 16'h0001);
        step();
        check("pin0_irq", {15'd0, bus.gpio_irq}, 16'h0001);
        bus.intr_clear = 16'h0001;
        step();
        bus.intr_clear = 16'h0000;
        step();
        check("pin0_clr", bus.gpio_intr_pending, 16'h0000);
        check("pin0_irq0", {15'd0, bus.gpio_irq}, 16'h0000);

        bus.rf_gpio_interrupt_mask = 16'h0000;
        v5 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v5 = ~v5;
            bus.gpio_in[5] = v5;
            repeat (2 + LAT) step();
            check("pin5_state", {15'd0, bus.ro_gpio_pinstate[5]}, {15'd0, v5});
        end
        repeat (3) step();
        check("pin5_nopend", bus.gpio_intr_pending, 16'h0000);
        check("pin5_noirq", {15'd0, bus.gpio_irq}, 16'h0000);

        bus.rf_gpio_interrupt_mask = 16'h0008;
        bus.gpio_in[3] = 1'b1;
        repeat (3 + LAT) step();
        check("pin3_pend", bus.gpio_intr_pending, 16'h0008);
        bus.gpio_in[3] = 1'b0;
        step();
        repeat (LAT + 1) step();
        bus.intr_clear = 16'h0008;
        step();
        bus.intr_clear = 16'h0000;
        check("set_wins", bus.gpio_intr_pending, 16'h0008);
        step();
        check("set_wins_irq", {15'd0, bus.gpio_irq}, 16'h0001);
        bus.intr_clear = 16'h0008;
        step();
        bus.intr_clear = 16'h0000;
        check("pin3_clr", bus.gpio_intr_pending, 16'h0000);
        step();
        check("pin3_irq0", {15'd0, bus.gpio_irq}, 16'h0000);

        bus.rf_gpio_interrupt_mask = 16'h0004;
        bus.gpio_in[2] = 1'b1;
        repeat (4 + LAT) step();
        check("pin2_pend", bus.gpio_intr_pending, 16'h0004);
        check("pin2_irq", {15'd0, bus.gpio_irq}, 16'h0001);
        bus.rf_gpio_interrupt_mask = 16'h0000;
        step();
        check("mask_irq0", {15'd0, bus.gpio_irq}, 16'h0000);
        check("mask_keep", bus.gpio_intr_pending, 16'h0004);
        bus.rf_gpio_interrupt_mask = 16'h0004;
        step();
        check("unmask_irq", {15'd0, bus.gpio_irq}, 16'h0001);
        bus.intr_clear = 16'h0004;
        step();
        bus.intr_clear = 16'h0000;
        step();

`ifdef GPIO_DEBOUNCE_EN
        bus.rf_gpio_interrupt_mask = 16'hFFFF;
        bus.gpio_in[7] = 1'b1;
        repeat (3) step();
        bus.gpio_in[7] = 1'b0;
        repeat (12) step();
        check("short_state", {15'd0, bus.ro_gpio_pinstate[7]}, 16'h0000);
        check("short_pend", bus.gpio_intr_pending, 16'h0000);
        bus.gpio_in[7] = 1'b1;
        repeat (6) step();
        check("long_state", {15'd0, bus.ro_gpio_pinstate[7]}, 16'h0001);
        bus.gpio_in[7] = 1'b0;
        step();
        check("long_pend", bus.gpio_intr_pending, 16'h0080);
        repeat (12) step();
        bus.intr_clear = 16'hFFFF;
        step();
        bus.intr_clear = 16'h0000;
        step();
`endif

        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0)
                bus.rf_gpio_datareg = 16'($urandom());
            if ($urandom_range(0, 7) == 0)
                bus.rf_gpio_tristate = 16'($urandom());
            if ($urandom_range(0, 15) == 0)
                bus.rf_gpio_interrupt_mask = 16'($urandom());
            if ($urandom_range(0, 3) == 0)
                bus.intr_clear = 16'($urandom());
            else
                bus.intr_clear = 16'h0000;
            if ($urandom_range(0, 2) == 0)
                bus.gpio_in[$urandom_range(0, 15)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0)
                bus.gpio_in = 16'($urandom());
            step();
        end
        reset = 1'b0;
        bus.intr_clear = 16'h0000;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
